// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command framer: state codes,
// default header bytes, the baud register address and the register-write payload.
package uart_cmd_pkg;

    localparam int unsigned ST_W   = 3;
    localparam int unsigned BAUD_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
    localparam logic [ST_W-1:0] ST_H1   = 3'd1;
    localparam logic [ST_W-1:0] ST_ADDR = 3'd2;
    localparam logic [ST_W-1:0] ST_DH   = 3'd3;
    localparam logic [ST_W-1:0] ST_DL   = 3'd4;
    localparam logic [ST_W-1:0] ST_CHK  = 3'd5;

    localparam logic [7:0] HDR0_DEF  = 8'h55;
    localparam logic [7:0] HDR1_DEF  = 8'hA5;
    localparam logic [7:0] ADDR_BAUD = 8'h00;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] wdata;
    } reg_wr_t;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter: counts idle cycles while enabled, clears on
// every byte, and flags expiry on the cycle the count reaches TIMEOUT_CYC-1.
module uart_frame_timer
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 500000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_c_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A byte arriving on the expiry cycle wins over the timeout.
    always_comb begin
        expire_c_o = en_i && !clr_i && (cnt_q == CNT_MAX);
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || !en_i || expire_c_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_frame_ctrl.sv
// Parses UART bytes into command frames and issues one register write per good frame.
// UART_CMD_CHKSUM_EN selects the 6-byte frame with checksum; otherwise frames are 5 bytes.
module uart_cmd_frame_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]        HDR0        = HDR0_DEF,
    parameter logic [7:0]        HDR1        = HDR1_DEF,
    parameter int unsigned       TIMEOUT_CYC = 500000,
    parameter int unsigned       CNT_W       = 20,
    parameter logic [BAUD_W-1:0] BAUD_RST    = 3'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_done_i,
    output logic [BAUD_W-1:0] baud_set_o,
    output logic [7:0]        reg_addr_o,
    output logic [15:0]       reg_wdata_o,
    output logic              reg_wr_o,
    output logic              frame_err_o,
    output logic              busy_o
);

    logic [ST_W-1:0]   state_q, state_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        dh_q, dh_d;
    reg_wr_t           wr_q, wr_d;
    logic              reg_wr_q, reg_wr_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              expire_c;
`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]        dl_q, dl_d;
    logic [7:0]        chk_q, chk_d;
`endif

    uart_frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .en_i       (state_q != ST_IDLE),
        .clr_i      (rx_done_i),
        .expire_c_o (expire_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rx_done_i) begin
            case (state_q)
                ST_IDLE: if (rx_byte_i == HDR0) state_d = ST_H1;
                ST_H1: begin
                    if (rx_byte_i == HDR1)      state_d = ST_ADDR;
                    else if (rx_byte_i != HDR0) state_d = ST_IDLE;
                end
                ST_ADDR: state_d = ST_DH;
                ST_DH:   state_d = ST_DL;
`ifdef UART_CMD_CHKSUM_EN
                ST_DL:   state_d = ST_CHK;
                ST_CHK:  state_d = ST_IDLE;
`else
                ST_DL:   state_d = ST_IDLE;
`endif
                default: state_d = ST_IDLE;
            endcase
        end else if (expire_c) begin
            state_d = ST_IDLE;
        end
    end

    // Field capture, commit of completed frames and error pulses.
    always_comb begin
        addr_d      = addr_q;
        dh_d        = dh_q;
        wr_d        = wr_q;
        reg_wr_d    = 1'b0;
        frame_err_d = 1'b0;
        baud_d      = baud_q;
        busy_d      = (state_d != ST_IDLE);
`ifdef UART_CMD_CHKSUM_EN
        dl_d        = dl_q;
        chk_d       = chk_q;
`endif
        if (rx_done_i) begin
            case (state_q)
                ST_ADDR: begin
                    addr_d = rx_byte_i;
`ifdef UART_CMD_CHKSUM_EN
                    chk_d  = rx_byte_i;
`endif
                end
                ST_DH: begin
                    dh_d  = rx_byte_i;
`ifdef UART_CMD_CHKSUM_EN
                    chk_d = chk_q + rx_byte_i;
`endif
                end
`ifdef UART_CMD_CHKSUM_EN
                ST_DL: begin
                    dl_d  = rx_byte_i;
                    chk_d = chk_q + rx_byte_i;
                end
                ST_CHK: begin
                    if (rx_byte_i == chk_q) begin
                        reg_wr_d = 1'b1;
                        wr_d     = '{addr: addr_q, wdata: {dh_q, dl_q}};
                        if (addr_q == ADDR_BAUD) baud_d = dl_q[BAUD_W-1:0];
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
`else
                ST_DL: begin
                    reg_wr_d = 1'b1;
                    wr_d     = '{addr: addr_q, wdata: {dh_q, rx_byte_i}};
                    if (addr_q == ADDR_BAUD) baud_d = rx_byte_i[BAUD_W-1:0];
                end
`endif
                default: ;
            endcase
        end else if (expire_c) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            dh_q        <= '0;
            wr_q        <= '0;
            reg_wr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            baud_q      <= BAUD_RST;
`ifdef UART_CMD_CHKSUM_EN
            dl_q        <= '0;
            chk_q       <= '0;
`endif
        end else begin
            addr_q      <= addr_d;
            dh_q        <= dh_d;
            wr_q        <= wr_d;
            reg_wr_q    <= reg_wr_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            baud_q      <= baud_d;
`ifdef UART_CMD_CHKSUM_EN
            dl_q        <= dl_d;
            chk_q       <= chk_d;
`endif
        end
    end

    assign baud_set_o  = baud_q;
    assign reg_addr_o  = wr_q.addr;
    assign reg_wdata_o = wr_q.wdata;
    assign reg_wr_o    = reg_wr_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_cmd_frame_ctrl.sv
// Randomized bench for uart_cmd_frame_ctrl against a queue-based frame model;
// follows UART_CMD_CHKSUM_EN to pick the frame length.
module tb_uart_cmd_frame_ctrl;

    localparam int TB_TIMEOUT = 100;
`ifdef UART_CMD_CHKSUM_EN
    localparam int FLEN = 6;
`else
    localparam int FLEN = 5;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_done;
    logic [2:0]  baud_set;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_wr;
    logic        frame_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: bytes of the frame collected so far.
    logic [7:0]  mq[$];
    int          idle;
    logic        exp_wr, exp_err;
    logic [7:0]  exp_addr;
    logic [15:0] exp_wdata;
    logic [2:0]  exp_baud;

    uart_cmd_frame_ctrl #(
        .TIMEOUT_CYC (TB_TIMEOUT),
        .CNT_W       (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_byte_i   (rx_byte),
        .rx_done_i   (rx_done),
        .baud_set_o  (baud_set),
        .reg_addr_o  (reg_addr),
        .reg_wdata_o (reg_wdata),
        .reg_wr_o    (reg_wr),
        .frame_err_o (frame_err),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        idle      = 0;
        exp_wr    = 1'b0;
        exp_err   = 1'b0;
        exp_addr  = 8'h00;
        exp_wdata = 16'h0000;
        exp_baud  = 3'd0;
    endtask

    task automatic model_step(input bit rxd, input logic [7:0] b);
        logic [7:0] sum;
        bit ok;
        exp_wr  = 1'b0;
        exp_err = 1'b0;
        if (rxd) begin
            idle = 0;
            if (mq.size() == 0) begin
                if (b == 8'h55) mq.push_back(b);
            end else if (mq.size() == 1) begin
                if (b == 8'hA5)      mq.push_back(b);
                else if (b != 8'h55) mq.delete();
            end else begin
                mq.push_back(b);
                if (mq.size() == FLEN) begin
                    sum = mq[2] + mq[3] + mq[4];
                    ok  = 1'b1;
`ifdef UART_CMD_CHKSUM_EN
                    ok  = (mq[5] == sum);
`endif
                    if (ok) begin
                        exp_wr    = 1'b1;
                        exp_addr  = mq[2];
                        exp_wdata = {mq[3], mq[4]};
                        if (mq[2] == 8'h00) exp_baud = mq[4][2:0];
                    end else begin
                        exp_err = 1'b1;
                    end
                    mq.delete();
                end
            end
        end else if (mq.size() != 0) begin
            idle++;
            if (idle == TB_TIMEOUT) begin
                mq.delete();
                idle    = 0;
                exp_err = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("reg_wr",    16'(reg_wr),    16'(exp_wr));
        check("frame_err", 16'(frame_err), 16'(exp_err));
        check("busy",      16'(busy),      16'(mq.size() != 0));
        check("reg_addr",  16'(reg_addr),  16'(exp_addr));
        check("reg_wdata", reg_wdata,      exp_wdata);
        check("baud_set",  16'(baud_set),  16'(exp_baud));
    endtask

    task automatic cycle(input bit rxd, input logic [7:0] b);
        @(negedge clk);
        rx_done = rxd;
        rx_byte = rxd ? b : 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        model_step(rxd, b);
        compare_all();
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) cycle(1'b0, 8'h00);
        cycle(1'b1, b);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl,
                              input bit good, input int gap);
        logic [7:0] chk;
        chk = a + dh + dl;
        if (!good) chk = chk ^ 8'($urandom_range(1, 255));
        send(8'h55, gap);
        send(8'hA5, gap);
        send(a, gap);
        send(dh, gap);
        send(dl, gap);
`ifdef UART_CMD_CHKSUM_EN
        send(chk, gap);
`endif
    endtask

    function automatic int rand_gap();
        if ($urandom_range(0, 19) == 0) return int'($urandom_range(TB_TIMEOUT - 2, TB_TIMEOUT + 1));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        int kind;
        rst     = 1'b1;
        rx_done = 1'b0;
        rx_byte = 8'h00;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        send_frame(8'h10, 8'h12, 8'h34, 1'b1, 0);
        send_frame(8'h00, 8'h00, 8'h03, 1'b1, 1);
        repeat (3) cycle(1'b0, 8'h00);
        send_frame(8'h10, 8'h12, 8'h34, 1'b0, 0);
        repeat (2) cycle(1'b0, 8'h00);
        send(8'h55, 0);
        send_frame(8'h20, 8'h00, 8'h01, 1'b1, 0);
        send(8'h55, 2);
        send(8'h7E, 0);
        repeat (3) cycle(1'b0, 8'h00);

        // Timeout after the address byte, then a byte landing on the expiry cycle.
        send(8'h55, 0);
        send(8'hA5, 0);
        send(8'h10, 0);
        repeat (TB_TIMEOUT + 3) cycle(1'b0, 8'h00);
        send(8'h55, 0);
        send(8'hA5, 0);
        send(8'h10, 0);
        send(8'h12, TB_TIMEOUT - 1);
        send(8'h34, 0);
`ifdef UART_CMD_CHKSUM_EN
        send(8'h56, 0);
`endif
        repeat (2) cycle(1'b0, 8'h00);
        send(8'h55, 0);
        repeat (TB_TIMEOUT + 2) cycle(1'b0, 8'h00);

        // Asynchronous reset mid-frame after a baud write.
        send_frame(8'h00, 8'h00, 8'h05, 1'b1, 0);
        send(8'h55, 0);
        send(8'hA5, 0);
        @(negedge clk);
        rx_done = 1'b0;
        rst     = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 5) begin
                send_frame(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255)),
                           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                           1'b1, ($urandom_range(0, 9) == 0) ? rand_gap() : 0);
            end else if (kind < 7) begin
                send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                           8'($urandom_range(0, 255)), 1'b0, int'($urandom_range(0, 1)));
            end else if (kind < 9) begin
                send(($urandom_range(0, 1) == 0) ? 8'h55 : 8'($urandom_range(0, 255)), rand_gap());
            end else begin
                send(8'h55, 0);
                send(8'hA5, 0);
                repeat (int'($urandom_range(TB_TIMEOUT - 2, TB_TIMEOUT + 2))) cycle(1'b0, 8'h00);
            end
        end
        repeat (TB_TIMEOUT + 2) cycle(1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
